// File: rtl/spi_router.sv
// -----------------------------------------------------------------------------
// spi_router
// Routes one host-side SPI port to one of NCH downstream SPI channels.
// The host pins and the channel select are synchronised into clk, then a
// four-state FSM (IDLE / ACTIVE / BLOCK / GUARD) forwards sck, csn and mosi to
// the channel latched at the start of the frame. The selected channel's miso
// is returned on the host miso. Every output comes straight from a flop.
//
// Optional feature macro: SPI_ROUTER_BITCNT_EN
//   defined   -> adds output bit_cnt[15:0], a count of sck rising edges seen
//                while ACTIVE. It saturates at 16'hFFFF, clears when a frame
//                starts and holds its value after the frame ends.
//   undefined -> bit_cnt and its counter are absent.
//
// Ports
//   clk      in   system clock, all logic on the rising edge
//   reset    in   asynchronous, active-low reset
//   spi_sel  in   [SEL_W] host channel select (sampled when a frame starts)
//   sck      in   host SPI clock
//   csn      in   host SPI chip select, active low
//   mosi     in   host SPI data out
//   miso     out  registered host SPI data in
//   ch_sck   out  [NCH] per-channel SPI clock   (idle high)
//   ch_csn   out  [NCH] per-channel chip select (idle high)
//   ch_mosi  out  [NCH] per-channel data out    (idle high)
//   ch_miso  in   [NCH] per-channel data in
//   busy     out  FSM is not IDLE
//   sel_err  out  one-cycle pulse when a frame starts with an invalid select
//   bit_cnt  out  [16] sck rising edge count (SPI_ROUTER_BITCNT_EN only)
// -----------------------------------------------------------------------------
module spi_router #(
  parameter int NCH         = 4,
  parameter int SEL_W       = 2,
  parameter int SYNC_STAGES = 2,
  parameter int GUARD_CYC   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SEL_W-1:0] spi_sel,
  input  logic             sck,
  input  logic             csn,
  input  logic             mosi,
  output logic             miso,
  output logic [NCH-1:0]   ch_sck,
  output logic [NCH-1:0]   ch_csn,
  output logic [NCH-1:0]   ch_mosi,
  input  logic [NCH-1:0]   ch_miso,
  output logic             busy,
  output logic             sel_err
`ifdef SPI_ROUTER_BITCNT_EN
  ,
  output logic [15:0]      bit_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_BLOCK  = 2'd2,
    ST_GUARD  = 2'd3
  } state_e;

  // NCH in a width that can be compared against a zero-extended select.
  localparam logic [SEL_W:0] NCH_L      = (SEL_W+1)'(NCH);
  localparam bit             HAS_GUARD  = (GUARD_CYC > 0);
  localparam logic [7:0]     GUARD_LAST = (GUARD_CYC > 0) ? 8'(GUARD_CYC - 1) : 8'd0;

  // One-hot decode of a channel index; indices >= NCH decode to all zeros.
  function automatic logic [NCH-1:0] sel_dec(input logic [SEL_W-1:0] s);
    logic [NCH-1:0] oh;
    oh = '0;
    for (int i = 0; i < NCH; i++) begin
      oh[i] = (s == SEL_W'(i));
    end
    return oh;
  endfunction

  // ---------------------------------------------------------------------------
  // Input synchronisers
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0]            sck_sync_q;
  logic [SYNC_STAGES-1:0]            csn_sync_q;
  logic [SYNC_STAGES-1:0]            mosi_sync_q;
  logic [SYNC_STAGES-1:0][SEL_W-1:0] sel_sync_q;

  logic             sck_s;
  logic             csn_s;
  logic             mosi_s;
  logic [SEL_W-1:0] sel_s;
  logic             sel_ok_s;

  // Shift host pins and select through SYNC_STAGES flops; pins reset to idle-high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_sync_q  <= '1;
      csn_sync_q  <= '1;
      mosi_sync_q <= '1;
      sel_sync_q  <= '0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], csn};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sel_sync_q  <= {sel_sync_q[SYNC_STAGES-2:0], spi_sel};
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign csn_s    = csn_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sel_s    = sel_sync_q[SYNC_STAGES-1];
  assign sel_ok_s = ({1'b0, sel_s} < NCH_L);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  state_e           state_q,     state_d;
  logic [SEL_W-1:0] cur_sel_q,   cur_sel_d;
  logic [7:0]       guard_cnt_q, guard_cnt_d;

  // State register, latched select and guard counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cur_sel_q   <= '0;
      guard_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cur_sel_q   <= cur_sel_d;
      guard_cnt_q <= guard_cnt_d;
    end
  end

  // Next-state logic; the select is only sampled in IDLE so it stays fixed for the frame.
  always_comb begin
    state_d     = state_q;
    cur_sel_d   = cur_sel_q;
    guard_cnt_d = guard_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (!csn_s) begin
          cur_sel_d = sel_s;
          if (sel_ok_s) begin
            state_d = ST_ACTIVE;
          end else begin
            state_d = ST_BLOCK;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (csn_s) begin
          guard_cnt_d = 8'd0;
          if (HAS_GUARD) begin
            state_d = ST_GUARD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_BLOCK: begin
        if (csn_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BLOCK;
        end
      end
      ST_GUARD: begin
        // csn falls here are deliberately ignored; IDLE re-evaluates csn_s afterwards.
        if (guard_cnt_q == GUARD_LAST) begin
          guard_cnt_d = 8'd0;
          state_d     = ST_IDLE;
        end else begin
          guard_cnt_d = guard_cnt_q + 8'd1;
          state_d     = ST_GUARD;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        guard_cnt_d = 8'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic [NCH-1:0] ch_sck_q,  ch_sck_d;
  logic [NCH-1:0] ch_csn_q,  ch_csn_d;
  logic [NCH-1:0] ch_mosi_q, ch_mosi_d;
  logic           miso_q,    miso_d;
  logic           busy_q,    busy_d;
  logic           sel_err_q, sel_err_d;
  logic [NCH-1:0] cur_hit_s;
  logic [NCH-1:0] new_hit_s;

  assign cur_hit_s = sel_dec(cur_sel_q);
  assign new_hit_s = sel_dec(sel_s);

  // Output decode. The IDLE->ACTIVE cycle already drives the new channel so
  // csn/sck/mosi reach the channel pins one register after the synchroniser.
  always_comb begin
    ch_sck_d  = '1;
    ch_csn_d  = '1;
    ch_mosi_d = '1;
    miso_d    = 1'b1;
    sel_err_d = 1'b0;
    busy_d    = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (!csn_s && sel_ok_s) begin
          ch_csn_d  = ~new_hit_s;
          ch_sck_d  = ~new_hit_s | ({NCH{sck_s}}  & new_hit_s);
          ch_mosi_d = ~new_hit_s | ({NCH{mosi_s}} & new_hit_s);
        end else if (!csn_s) begin
          sel_err_d = 1'b1;
        end else begin
          sel_err_d = 1'b0;
        end
      end
      ST_ACTIVE: begin
        miso_d = |(ch_miso & cur_hit_s);
        // On csn_s rise every channel returns to idle-high in this same cycle.
        if (!csn_s) begin
          ch_csn_d  = ~cur_hit_s;
          ch_sck_d  = ~cur_hit_s | ({NCH{sck_s}}  & cur_hit_s);
          ch_mosi_d = ~cur_hit_s | ({NCH{mosi_s}} & cur_hit_s);
        end else begin
          ch_csn_d  = '1;
        end
      end
      default: begin
        miso_d = 1'b1;
      end
    endcase
  end

  // Output registers; reset forces every channel idle-high without a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ch_sck_q  <= '1;
      ch_csn_q  <= '1;
      ch_mosi_q <= '1;
      miso_q    <= 1'b1;
      busy_q    <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      ch_sck_q  <= ch_sck_d;
      ch_csn_q  <= ch_csn_d;
      ch_mosi_q <= ch_mosi_d;
      miso_q    <= miso_d;
      busy_q    <= busy_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign ch_sck  = ch_sck_q;
  assign ch_csn  = ch_csn_q;
  assign ch_mosi = ch_mosi_q;
  assign miso    = miso_q;
  assign busy    = busy_q;
  assign sel_err = sel_err_q;

`ifdef SPI_ROUTER_BITCNT_EN
  // ---------------------------------------------------------------------------
  // Bit counter
  // ---------------------------------------------------------------------------
  logic        sck_prev_q;
  logic [15:0] bit_cnt_q, bit_cnt_d;

  // Counts synchronised sck rising edges while ACTIVE; saturating.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if ((state_q == ST_IDLE) && (state_d == ST_ACTIVE)) begin
      bit_cnt_d = 16'd0;
    end else if ((state_q == ST_ACTIVE) && sck_s && !sck_prev_q &&
                 (bit_cnt_q != 16'hFFFF)) begin
      bit_cnt_d = bit_cnt_q + 16'd1;
    end else begin
      bit_cnt_d = bit_cnt_q;
    end
  end

  // Edge-detect history and counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_prev_q <= 1'b1;
      bit_cnt_q  <= 16'd0;
    end else begin
      sck_prev_q <= sck_s;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  assign bit_cnt = bit_cnt_q;
`endif

endmodule

// File: tb/tb_spi_router.sv
// Directed testbench for spi_router: a 4-channel instance carries most of the
// traffic, and a 3-channel instance shares the host pins to exercise the
// invalid-select path. Host SPI is driven in mode 3 (sck idle high, data
// changes on the falling edge, sampled on the rising edge).
module tb_spi_router;

  localparam int GUARD = 4;

  logic       clk;
  logic       reset;
  logic       sck, csn, mosi;
  logic [1:0] sel4, sel3;
  logic [3:0] ch_miso4;
  logic [2:0] ch_miso3;
  logic       miso4, busy4, sel_err4;
  logic       miso3, busy3, sel_err3;
  logic [3:0] ch_sck4, ch_csn4, ch_mosi4;
  logic [2:0] ch_sck3, ch_csn3, ch_mosi3;
`ifdef SPI_ROUTER_BITCNT_EN
  logic [15:0] bit_cnt4, bit_cnt3;
`endif

  spi_router #(.NCH(4), .SEL_W(2), .SYNC_STAGES(2), .GUARD_CYC(GUARD)) u_dut4 (
    .clk(clk), .reset(reset), .spi_sel(sel4), .sck(sck), .csn(csn), .mosi(mosi),
    .miso(miso4), .ch_sck(ch_sck4), .ch_csn(ch_csn4), .ch_mosi(ch_mosi4),
    .ch_miso(ch_miso4), .busy(busy4), .sel_err(sel_err4)
`ifdef SPI_ROUTER_BITCNT_EN
    , .bit_cnt(bit_cnt4)
`endif
  );

  spi_router #(.NCH(3), .SEL_W(2), .SYNC_STAGES(2), .GUARD_CYC(GUARD)) u_dut3 (
    .clk(clk), .reset(reset), .spi_sel(sel3), .sck(sck), .csn(csn), .mosi(mosi),
    .miso(miso3), .ch_sck(ch_sck3), .ch_csn(ch_csn3), .ch_mosi(ch_mosi3),
    .ch_miso(ch_miso3), .busy(busy3), .sel_err(sel_err3)
`ifdef SPI_ROUTER_BITCNT_EN
    , .bit_cnt(bit_cnt3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int lat_bad;
  logic [31:0] rx;

  // Channel-side monitor, sampled 2 time units after each rising edge.
  int          rise4 [4] = '{0, 0, 0, 0};
  int          act4  [4] = '{0, 0, 0, 0};
  logic [31:0] sh4   [4];
  logic [3:0]  sck_prev4 = 4'hF;
  int          act3 = 0;
  int          err3_cnt = 0;
  int          miso3_low = 0;

  always begin
    @(posedge clk);
    #2;
    for (int k = 0; k < 4; k++) begin
      if (ch_sck4[k] && !sck_prev4[k]) begin
        rise4[k] = rise4[k] + 1;
        sh4[k]   = {sh4[k][30:0], ch_mosi4[k]};
      end
      if (!(ch_sck4[k] && ch_csn4[k] && ch_mosi4[k])) act4[k] = act4[k] + 1;
    end
    sck_prev4 = ch_sck4;
    if (!((&ch_csn3) && (&ch_sck3) && (&ch_mosi3))) act3 = act3 + 1;
    if (sel_err3) err3_cnt = err3_cnt + 1;
    if (!miso3) miso3_low = miso3_low + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shift n bits MSB first; channel mch returns pat, the other channels its inverse.
  // Each bit also measures the host->channel sck latency on channel mch.
  task automatic shift_bits(input logic [31:0] tx, input int n, input int mch,
                            input logic [31:0] pat);
    logic s2, s3;
    for (int i = n - 1; i >= 0; i--) begin
      sck  = 1'b0;
      mosi = tx[i];
      for (int k = 0; k < 4; k++) ch_miso4[k] = (k == mch) ? pat[i] : ~pat[i];
      tick(2); s2 = ch_sck4[mch];
      tick(1); s3 = ch_sck4[mch];
      if (!(s2 === 1'b1 && s3 === 1'b0)) lat_bad++;
      tick(1); rx = {rx[30:0], miso4};
      sck = 1'b1;
      tick(4);
    end
  endtask

  int a0, a1, a3, r1, r2, e3, m3, hi;
  bit seen, done;
  logic busy_g;

  initial begin
    reset = 1'b0; sck = 1'b1; csn = 1'b1; mosi = 1'b1;
    sel4 = 2'd0; sel3 = 2'd0; ch_miso4 = 4'hF; ch_miso3 = 3'b000;
    tick(3);
    // Reset values.
    chk("rst_ch_csn4", ch_csn4, 4'hF);
    chk("rst_ch_sck4", ch_sck4, 4'hF);
    chk("rst_ch_mosi4", ch_mosi4, 4'hF);
    chk("rst_miso4", miso4, 1'b1);
    chk("rst_busy4", busy4, 1'b0);
    chk("rst_sel_err4", sel_err4, 1'b0);
    chk("rst_ch_csn3", ch_csn3, 3'h7);
    chk("rst_miso3", miso3, 1'b1);
    reset = 1'b1;
    tick(3);

    // 16-bit frame on channel 2 with latency checks.
    sel4 = 2'd2; tick(4);
    a0 = act4[0]; a1 = act4[1]; a3 = act4[3]; r2 = rise4[2];
    csn = 1'b0;
    tick(2); chk("csn_fall_lat2", ch_csn4[2], 1'b1);
    tick(1); chk("csn_fall_lat3", ch_csn4[2], 1'b0);
    chk("busy_active", busy4, 1'b1);
    tick(3);
    rx = '0; lat_bad = 0;
    shift_bits(32'h3C5A, 16, 2, 32'hA5C3);
    tick(2); csn = 1'b1;
    tick(2); chk("csn_rise_lat2", ch_csn4[2], 1'b0);
    tick(1); chk("csn_rise_lat3", ch_csn4[2], 1'b1);
    tick(10);
    chk("busy_idle", busy4, 1'b0);
    chk("f1_miso", rx[15:0], 16'hA5C3);
    chk("f1_ch2_data", sh4[2][15:0], 16'h3C5A);
    chk("f1_ch2_edges", rise4[2] - r2, 16);
    chk("f1_ch0_quiet", act4[0] - a0, 0);
    chk("f1_ch1_quiet", act4[1] - a1, 0);
    chk("f1_ch3_quiet", act4[3] - a3, 0);
    chk("f1_sck_lat", lat_bad, 0);

    // Select changed mid-frame is ignored.
    sel4 = 2'd1; tick(4);
    a3 = act4[3]; r1 = rise4[1];
    csn = 1'b0; tick(6);
    rx = '0; lat_bad = 0;
    shift_bits(32'h9E, 8, 1, 32'h0F);
    sel4 = 2'd3;
    shift_bits(32'h21, 8, 1, 32'hF0);
    tick(2); csn = 1'b1; tick(12);
    chk("f2_ch1_data", sh4[1][15:0], 16'h9E21);
    chk("f2_ch1_edges", rise4[1] - r1, 16);
    chk("f2_ch3_quiet", act4[3] - a3, 0);
    chk("f2_miso", rx[15:0], 16'h0FF0);
    chk("f2_sck_lat", lat_bad, 0);

    // Invalid select on the 3-channel instance.
    sel3 = 2'd3; sel4 = 2'd0; tick(4);
    a0 = act3; e3 = err3_cnt; m3 = miso3_low;
    csn = 1'b0; tick(6);
    chk("blk_busy_start", busy3, 1'b1);
    rx = '0;
    shift_bits(32'h5A, 8, 0, 32'h33);
    chk("blk_busy_mid", busy3, 1'b1);
    tick(2); csn = 1'b1; tick(12);
    chk("blk_sel_err_pulse", err3_cnt - e3, 1);
    chk("blk_no_channel", act3 - a0, 0);
    chk("blk_miso_high", miso3_low - m3, 0);
    chk("blk_busy_end", busy3, 1'b0);
    sel3 = 2'd0;

    // Guard: csn re-asserted 2 clk after deselect.
    sel4 = 2'd2; tick(4);
    csn = 1'b0; tick(6);
    shift_bits(32'hC3, 8, 2, 32'h96);
    tick(2); csn = 1'b1;
    hi = 0; seen = 1'b0; done = 1'b0; busy_g = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      tick(1);
      if (c == 1) csn = 1'b0;
      if (c == 4) busy_g = busy4;
      if (ch_csn4[2]) begin
        seen = 1'b1;
        hi++;
      end else if (seen) begin
        done = 1'b1;
      end
    end
    chk("guard_restart", done, 1'b1);
    chk("guard_len", (hi >= GUARD && hi <= GUARD + 1), 1'b1);
    chk("guard_busy", busy_g, 1'b1);
    rx = '0; lat_bad = 0;
    shift_bits(32'hA7, 8, 2, 32'h3C);
    tick(2); csn = 1'b1; tick(12);
    chk("guard_next_data", sh4[2][7:0], 8'hA7);
    chk("guard_next_miso", rx[7:0], 8'h3C);

    // Reset pulsed after bit 7 with csn held low.
    csn = 1'b0; tick(6);
    rx = '0; lat_bad = 0;
    shift_bits(32'hB14D >> 9, 7, 2, 32'hE187 >> 9);
    #2 reset = 1'b0;
    #1;
    chk("rst_async_csn", ch_csn4[2], 1'b1);
    chk("rst_mid_sck", ch_sck4, 4'hF);
    chk("rst_mid_mosi", ch_mosi4, 4'hF);
    chk("rst_mid_miso", miso4, 1'b1);
    chk("rst_mid_busy", busy4, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    tick(2); chk("rst_resume_lat2", ch_csn4[2], 1'b1);
    tick(1); chk("rst_resume_lat3", ch_csn4[2], 1'b0);
    shift_bits(32'hB14D & 32'h1FF, 9, 2, 32'hE187 & 32'h1FF);
    tick(2); csn = 1'b1; tick(12);
    chk("rst_frame_data", sh4[2][15:0], 16'hB14D);
    chk("rst_frame_miso", rx[15:0], 16'hE187);
    chk("rst_sck_lat", lat_bad, 0);

`ifdef SPI_ROUTER_BITCNT_EN
    // Bit counter: 24-bit frame, then cleared by the next frame.
    csn = 1'b0; tick(6);
    shift_bits(32'hABCDEF, 24, 2, 32'h0);
    tick(2); csn = 1'b1; tick(4);
    chk("bitcnt_24", bit_cnt4, 16'd24);
    tick(12);
    chk("bitcnt_hold", bit_cnt4, 16'd24);
    csn = 1'b0; tick(6);
    chk("bitcnt_clear", bit_cnt4, 16'd0);
    shift_bits(32'h55, 8, 2, 32'h0);
    tick(2); csn = 1'b1; tick(12);
    chk("bitcnt_8", bit_cnt4, 16'd8);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
